fp_mult_approx_pipe: RTL and testbench



---
 rtl/fp_mult_pkg.sv | 20 ++
 rtl/fp_mult_approx_pipe_if.sv | 32 +++
 rtl/drum_mant_mult.sv | 31 +++
 rtl/fp_mult_approx_pipe.sv | 129 ++++++++++++
 tb/tb_fp_mult_approx_pipe.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mult_pkg.sv
// Shared widths, encodings and the unpacked-operand type for the approximate FP multiplier.
package fp_mult_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_DRUM_K = 8;
  localparam int FP_W      = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_BIAS   = (1 << (FP_EXP_W - 1)) - 1;

  localparam logic [FP_W-1:0] FP_QNAN     = {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};
  localparam logic [FP_W-1:0] FP_POS_INF  = {1'b0, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
  localparam logic [FP_W-1:0] FP_POS_ZERO = '0;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W:0]   sig;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_mult_approx_pipe_if.sv
// Operand/result valid-ready bundle for fp_mult_approx_pipe.
interface fp_mult_approx_pipe_if
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         in_approx;
  logic [W-1:0] a_operand;
  logic [W-1:0] b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         exception;
  logic         overflow;
  logic         underflow;

  modport master (
    output in_valid, in_approx, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, exception, overflow, underflow
  );

  modport slave (
    input  in_valid, in_approx, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, exception, overflow, underflow
  );

endinterface

// File: rtl/drum_mant_mult.sv
// Combinational significand multiplier: exact product or DRUM approximation on the top DRUM_K bits.
module drum_mant_mult
  import fp_mult_pkg::*;
#(
  parameter int MAN_W  = FP_MAN_W,
  parameter int DRUM_K = FP_DRUM_K
) (
  input  logic [MAN_W:0]         sig_a,
  input  logic [MAN_W:0]         sig_b,
  input  logic                   approx,
  output logic [2*(MAN_W+1)-1:0] product
);
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int SH = 2 * (SW - DRUM_K);

  logic [DRUM_K-1:0]   ka, kb;
  logic [2*DRUM_K-1:0] kprod;
  logic [PW-1:0]       exact, apx;

  assign exact = {{SW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b};

  // Forcing the kept LSB to 1 centres the truncation error of the dropped bits.
  assign ka    = sig_a[SW-1 -: DRUM_K] | DRUM_K'(1);
  assign kb    = sig_b[SW-1 -: DRUM_K] | DRUM_K'(1);
  assign kprod = {{DRUM_K{1'b0}}, ka} * {{DRUM_K{1'b0}}, kb};
  assign apx   = PW'(kprod) << SH;

  assign product = approx ? apx : exact;

endmodule

// File: rtl/fp_mult_approx_pipe.sv
// Three-stage FP multiplier (unpack, significand multiply, normalise/pack) with global-stall handshake.
module fp_mult_approx_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MAN_W  = FP_MAN_W,
  parameter int DRUM_K = FP_DRUM_K
) (
  input logic                  clk,
  input logic                  rst,
  fp_mult_approx_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0] EMIN = EW'(1);

  function automatic logic [W-1:0] pack_result(input logic sign, input logic zero, input logic exc,
                                               input logic ovf, input logic unf,
                                               input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (exc)              return {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (zero || unf) return {sign, {(W-1){1'b0}}};
    else if (ovf)         return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                  return {sign, e, m};
  endfunction

  logic advance;
  logic vld_p0_q, vld_p1_q, vld_p2_q;

  logic [EXP_W-1:0]     exp_a, exp_b;
  logic                 sign_d, zero_d, exc_d;
  logic signed [EW-1:0] esum_d;
  logic [SW-1:0]        sig_a_d, sig_b_d;

  logic                 sign_p0_q, zero_p0_q, exc_p0_q, approx_p0_q;
  logic signed [EW-1:0] esum_p0_q;
  logic [SW-1:0]        sig_a_p0_q, sig_b_p0_q;

  logic [PW-1:0]        prod_d, prod_p1_q;
  logic                 sign_p1_q, zero_p1_q, exc_p1_q;
  logic signed [EW-1:0] esum_p1_q;

  logic                 norm;
  logic signed [EW-1:0] e_d;
  logic [MAN_W-1:0]     mant_d;
  logic                 ovf_d, unf_d;
  logic [W-1:0]         result_d, result_q;
  logic                 exc_q, ovf_q, unf_q;
  logic                 unused_prod_lsbs;

  assign advance      = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = advance;

  // ---- stage 1: unpack ----
  assign exp_a   = bus.a_operand[MAN_W +: EXP_W];
  assign exp_b   = bus.b_operand[MAN_W +: EXP_W];
  assign sign_d  = bus.a_operand[W-1] ^ bus.b_operand[W-1];
  assign zero_d  = (exp_a == '0) || (exp_b == '0);
  assign exc_d   = (&exp_a) || (&exp_b);
  assign esum_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
  assign sig_a_d = {1'b1, bus.a_operand[MAN_W-1:0]};
  assign sig_b_d = {1'b1, bus.b_operand[MAN_W-1:0]};

  // ---- stage 2: significand multiply ----
  drum_mant_mult #(.MAN_W(MAN_W), .DRUM_K(DRUM_K)) u_mult (
    .sig_a   (sig_a_p0_q),
    .sig_b   (sig_b_p0_q),
    .approx  (approx_p0_q),
    .product (prod_d)
  );

  // ---- stage 3: normalise and pack ----
  assign norm     = prod_p1_q[PW-1];
  assign e_d      = esum_p1_q + $signed({{(EW-1){1'b0}}, norm});
  assign mant_d   = norm ? prod_p1_q[PW-2 -: MAN_W] : prod_p1_q[PW-3 -: MAN_W];
  assign ovf_d    = !zero_p1_q && !exc_p1_q && (e_d > EMAX);
  assign unf_d    = !zero_p1_q && !exc_p1_q && (e_d < EMIN);
  assign result_d = pack_result(sign_p1_q, zero_p1_q, exc_p1_q, ovf_d, unf_d, e_d[EXP_W-1:0], mant_d);

  // Bits below the retained mantissa are truncated away.
  assign unused_prod_lsbs = ^prod_p1_q[PW-3-MAN_W:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (advance) begin
      vld_p0_q <= bus.in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
      result_q <= vld_p1_q ? result_d : '0;
      exc_q    <= vld_p1_q & exc_p1_q;
      ovf_q    <= vld_p1_q & ovf_d;
      unf_q    <= vld_p1_q & unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p0_q   <= sign_d;
      zero_p0_q   <= zero_d;
      exc_p0_q    <= exc_d;
      approx_p0_q <= bus.in_approx;
      esum_p0_q   <= esum_d;
      sig_a_p0_q  <= sig_a_d;
      sig_b_p0_q  <= sig_b_d;
      prod_p1_q   <= prod_d;
      sign_p1_q   <= sign_p0_q;
      zero_p1_q   <= zero_p0_q;
      exc_p1_q    <= exc_p0_q;
      esum_p1_q   <= esum_p0_q;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.result    = result_q;
  assign bus.exception = exc_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_fp_mult_approx_pipe.sv
// Bench for fp_mult_approx_pipe: fixed vectors, stall/reset sequences and a random scoreboard run.
module tb_fp_mult_approx_pipe;
  import fp_mult_pkg::*;

  typedef struct packed {
    logic [31:0] r;
    logic        e;
    logic        o;
    logic        u;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        approx;
    exp_t        want;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  vec_t vecs[$];

  fp_mult_approx_pipe_if bus ();

  fp_mult_approx_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // Reference: real-number significand products from the field values, then IEEE-style packing.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic approx);
    fp_unpacked_t    ua, ub;
    longint unsigned pa, pb, p;
    int              e;
    logic [22:0]     m;
    logic            zero;
    exp_t            r;
    ua.sign = a[31]; ua.exp = a[30:23]; ua.sig = {1'b1, a[22:0]};
    ub.sign = b[31]; ub.exp = b[30:23]; ub.sig = {1'b1, b[22:0]};
    pa = 64'(ua.sig);
    pb = 64'(ub.sig);
    if (approx) begin
      pa = (pa / (64'd1 << (24 - FP_DRUM_K))) | 64'd1;
      pb = (pb / (64'd1 << (24 - FP_DRUM_K))) | 64'd1;
      p  = (pa * pb) * (64'd1 << (2 * (24 - FP_DRUM_K)));
    end else begin
      p = pa * pb;
    end
    e = int'(ua.exp) + int'(ub.exp) - FP_BIAS;
    if (p >= (64'd1 << 47)) begin
      e = e + 1;
      m = 23'((p >> 24) % (64'd1 << 23));
    end else begin
      m = 23'((p >> 23) % (64'd1 << 23));
    end
    zero = (ua.exp == 8'd0) || (ub.exp == 8'd0);
    r.e  = (ua.exp == 8'hFF) || (ub.exp == 8'hFF);
    r.o  = !zero && !r.e && (e > 254);
    r.u  = !zero && !r.e && (e < 1);
    if (r.e)              r.r = FP_QNAN;
    else if (zero || r.u) r.r = {ua.sign ^ ub.sign, 31'd0};
    else if (r.o)         r.r = {ua.sign ^ ub.sign, 8'hFF, 23'd0};
    else                  r.r = {ua.sign ^ ub.sign, 8'(e), m};
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] ex;
    case ($urandom_range(0, 9))
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      2:       ex = 8'($urandom);
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic approx, input logic [31:0] r,
                              input logic e, input logic o, input logic u);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.approx = approx;
    v.want.r = r; v.want.e = e; v.want.o = o; v.want.u = u;
    return v;
  endfunction

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic approx,
                         output exp_t got, output int lat);
    bus.a_operand = a;
    bus.b_operand = b;
    bus.in_approx = approx;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got.r = bus.result;
    got.e = bus.exception;
    got.o = bus.overflow;
    got.u = bus.underflow;
  endtask

  task automatic stream(input string tag, input int n, input bit directed);
    int          issued = 0;
    int          got = 0;
    int          cyc = 0;
    bit          held = 1'b0;
    logic [31:0] held_r = '0;
    exp_t        w;
    while ((issued < n || q.size() != 0) && cyc < 4000) begin
      if (issued < n) begin
        bus.in_valid  = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.a_operand = rand_op();
        bus.b_operand = rand_op();
        bus.in_approx = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = directed ? !(cyc >= 4 && cyc < 9) : ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_hold_result"}, bus.result, held_r);
      end
      if (bus.out_valid && !bus.out_ready) check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a_operand, bus.b_operand, bus.in_approx));
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL %s_extra: got result %h with nothing expected", tag, bus.result);
        end else begin
          w = q.pop_front();
          check({tag, "_result"}, bus.result, w.r);
          check({tag, "_flags"}, {29'd0, bus.exception, bus.overflow, bus.underflow}, {29'd0, w.e, w.o, w.u});
          got++;
        end
      end
      held   = bus.out_valid && !bus.out_ready;
      held_r = bus.result;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (issued != n || q.size() != 0) fail_now({tag, "_drain"});
    check({tag, "_count"}, 32'(got), 32'(n));
    q.delete();
  endtask

  initial begin
    exp_t got;
    int   lat;

    vecs.push_back(mk("exact_2x3",    32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 0, 0, 0));
    vecs.push_back(mk("exact_1p5sq",  32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 0, 0, 0));
    vecs.push_back(mk("drum_1p5sq",   32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40118100, 0, 0, 0));
    vecs.push_back(mk("drum_1x1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h3F820200, 0, 0, 0));
    vecs.push_back(mk("ovf_big",      32'h7F000000, 32'h7F000000, 1'b0, FP_POS_INF,   0, 1, 0));
    vecs.push_back(mk("ovf_edge255",  32'h7F000000, 32'h40000000, 1'b0, FP_POS_INF,   0, 1, 0));
    vecs.push_back(mk("no_ovf_e254",  32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 0, 0, 0));
    vecs.push_back(mk("ovf_neg",      32'hFF000000, 32'h7F000000, 1'b0, 32'hFF800000, 0, 1, 0));
    vecs.push_back(mk("unf_tiny",     32'h00800000, 32'h00800000, 1'b0, FP_POS_ZERO,  0, 0, 1));
    vecs.push_back(mk("unf_edge0",    32'h00800000, 32'h3F000000, 1'b0, FP_POS_ZERO,  0, 0, 1));
    vecs.push_back(mk("no_unf_e1",    32'h00800000, 32'h3F800000, 1'b0, 32'h00800000, 0, 0, 0));
    vecs.push_back(mk("neg_zero",     32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 0, 0, 0));
    vecs.push_back(mk("inf_exc",      32'h7F800000, 32'h3F800000, 1'b0, FP_QNAN,      1, 0, 0));
    vecs.push_back(mk("nan_x_zero",   32'h7FC00000, 32'h00000000, 1'b1, FP_QNAN,      1, 0, 0));

    bus.in_valid = 1'b0; bus.in_approx = 1'b0; bus.out_ready = 1'b0;
    bus.a_operand = '0; bus.b_operand = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {29'd0, bus.exception, bus.overflow, bus.underflow}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].approx, got, lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
      check({vecs[i].name, "_result"}, got.r, vecs[i].want.r);
      check({vecs[i].name, "_flags"}, {29'd0, got.e, got.o, got.u},
            {29'd0, vecs[i].want.e, vecs[i].want.o, vecs[i].want.u});
    end
    @(posedge clk); #1;

    stream("stall6", 6, 1'b1);

    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.a_operand = 32'h40000000 + 32'(k << 20);
      bus.b_operand = 32'h40400000;
      bus.in_approx = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_flush_valid", 32'(bus.out_valid), 32'd0);
    check("reset_flush_result", bus.result, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("no_stale_output", 32'(bus.out_valid), 32'd0);
    end
    run_one(32'h40000000, 32'h40400000, 1'b0, got, lat);
    check("post_reset_latency", 32'(lat), 32'd3);
    check("post_reset_result", got.r, 32'h40C00000);
    @(posedge clk); #1;

    stream("random", 300, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
